// File: rtl/pp_accumulator.sv
// Signed partial-product accumulator: sums shifted {hidden, mant} terms into one dot product.
// Optional build macro PP_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module pp_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       signed_pp,
    input  logic [4:0]       exp,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf
);

    // A 4-bit magnitude shifted by up to 31 needs 35 bits; the term carries one extra sign bit.
    localparam int MAG_W = 35;
    localparam int TW    = (ACC_W > MAG_W) ? ACC_W : MAG_W;
    localparam int SW    = TW + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;

    logic             accept;
    logic [MAG_W-1:0] mag;
    logic [TW:0]      term_mag;
    logic [TW:0]      term;
    logic [SW-1:0]    base_ext;
    logic [SW-1:0]    sum;
    logic [SW-ACC_W:0] sum_top;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_sum;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;

    assign acc_out  = acc;
    assign term_cnt = cnt;
    assign ovf      = ovf_q;

    // Term datapath: a cleared hidden bit marks a zero term whatever the sign and shift.
    assign mag      = {{(MAG_W-4){1'b0}}, signed_pp[3], signed_pp[2:0]} << exp;
    assign term_mag = signed_pp[3] ? {{(TW+1-MAG_W){1'b0}}, mag} : '0;
    assign term     = signed_pp[4] ? ('0 - term_mag) : term_mag;

    // The first term of a dot product adds to zero so its own range check is shared with the adder.
    assign base_ext = (state == IDLE) ? '0 : {{(SW-ACC_W){acc[ACC_W-1]}}, acc};
    assign sum      = base_ext + {term[TW], term};

    // The exact sum fits in ACC_W signed bits only if every bit from ACC_W-1 upward matches.
    assign sum_top  = sum[SW-1:ACC_W-1];
    assign add_ovf  = !((&sum_top) || !(|sum_top));

`ifdef PP_ACC_SATURATE_EN
    assign acc_sum = !add_ovf      ? sum[ACC_W-1:0] :
                     sum[SW-1]     ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign acc_sum = sum[ACC_W-1:0];
`endif

    always_comb begin
        // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset outranks every handshake, so a partial or held result is simply dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                acc <= acc_sum;
                if (state == IDLE) begin
                    cnt   <= CNT_W'(1);
                    ovf_q <= add_ovf;
                end else begin
                    cnt   <= (&cnt) ? cnt : cnt + 1'b1;
                    ovf_q <= ovf_q | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// Scoreboard bench for pp_accumulator: a default-width instance for dataflow and a 36-bit one for overflow.
module tb_pp_accumulator;

    localparam int ACC_W = 40;
    localparam int ACC_B = 36;
    localparam int CNT_W = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       signed_pp;
    logic [4:0]       exp;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] term_cnt;
    logic             ovf;

    logic             b_in_valid;
    logic             b_in_ready;
    logic [4:0]       b_pp;
    logic [4:0]       b_exp;
    logic             b_last;
    logic             b_out_valid;
    logic             b_out_ready;
    logic [ACC_B-1:0] b_acc;
    logic [CNT_W-1:0] b_cnt;
    logic             b_ovf;

    res_t sb[$];
    int   checks = 0;
    int   passed = 0;

    pp_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .signed_pp(signed_pp), .exp(exp), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf)
    );

    pp_accumulator #(.ACC_W(ACC_B), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .signed_pp(b_pp), .exp(b_exp), .in_last(b_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc), .term_cnt(b_cnt), .ovf(b_ovf)
    );

    function automatic longint term_val(logic [4:0] pp, logic [4:0] e);
        longint m;
        if (!pp[3]) return 0;
        m = longint'({pp[3], pp[2:0]}) << e;
        return pp[4] ? -m : m;
    endfunction

    // Scoreboard: every consumed result must match the oldest expectation.
    always @(negedge clk) begin
        res_t r;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected acc_out=%0d term_cnt=%0d ovf=%b required no result",
                         $signed(acc_out), term_cnt, ovf);
            end else begin
                r = sb.pop_front();
                if ({acc_out, term_cnt, ovf} !== {r.acc, r.cnt, r.ovf})
                    $display("FAIL sb_result acc_out=%0d term_cnt=%0d ovf=%b required acc=%0d cnt=%0d ovf=%b",
                             $signed(acc_out), term_cnt, ovf, $signed(r.acc), r.cnt, r.ovf);
                else
                    passed++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input longint a, input int c, input logic o);
        res_t r;
        r.acc = ACC_W'(a);
        r.cnt = CNT_W'(c);
        r.ovf = o;
        sb.push_back(r);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the term.
    task automatic send_term(input logic [4:0] pp, input logic [4:0] e, input logic last);
        int waited = 0;
        signed_pp = pp;
        exp       = e;
        in_last   = last;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [4:0] pp, input logic [4:0] e, input logic last);
        int waited = 0;
        b_pp       = pp;
        b_exp      = e;
        b_last     = last;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!b_in_ready) begin
            checks++;
            $display("FAIL send_b_timeout in_ready=%b required 1 within 50 cycles", b_in_ready);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_last     = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        signed_pp = 5'b01111;
        exp = 5'd4;
        in_last = 1'b1;
        step(2);
        checks++;
        if ({acc_out, term_cnt, ovf} !== '0)
            $display("FAIL reset_regs acc_out=%0d term_cnt=%0d ovf=%b required 0/0/0", acc_out, term_cnt, ovf);
        else passed++;
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else passed++;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        send_term(5'b01101, 5'd2, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_early out_valid=%b required 0", out_valid);
        else passed++;
        push_exp(44, 2, 1'b0);
        send_term(5'b11000, 5'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency out_valid=%b required 1", out_valid);
        else passed++;
        step(1);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_release out_valid=%b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_zero_terms();
        push_exp(0, 1, 1'b0);
        send_term(5'b00000, 5'd9, 1'b1);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL zero_single out_valid=%b required 1", out_valid);
        else passed++;
        step(1);
        // Hidden bit clear with sign set and a large shift still contributes nothing.
        push_exp(8, 2, 1'b0);
        send_term(5'b10111, 5'd5, 1'b0);
        send_term(5'b01000, 5'd0, 1'b1);
        step(1);
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        push_exp(term_val(5'b01110, 5'd3), 1, 1'b0);
        send_term(5'b01110, 5'd3, 1'b1);
        in_valid  = 1'b1;
        signed_pp = 5'b01010;
        exp       = 5'd0;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, out_valid} !== 2'b01 || acc_out !== ACC_W'(112))
                $display("FAIL hold_stable cycle=%0d in_ready=%b out_valid=%b acc_out=%0d required 0/1/112",
                         i, in_ready, out_valid, acc_out);
            else passed++;
            step(1);
        end
        out_ready = 1'b1;
        push_exp(10, 1, 1'b0);
        step(1);
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL hold_exit in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else passed++;
        step(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL hold_next_accept out_valid=%b required 1", out_valid);
        else passed++;
        step(1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send_term(5'b01001, 5'd0, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, term_cnt, acc_out} !== {2'b01, {CNT_W{1'b0}}, {ACC_W{1'b0}}})
            $display("FAIL reset_accum out_valid=%b in_ready=%b term_cnt=%0d acc_out=%0d required 0/1/0/0",
                     out_valid, in_ready, term_cnt, acc_out);
        else passed++;
        step(2);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_accum_quiet out_valid=%b required 0", out_valid);
        else passed++;
        push_exp(16, 1, 1'b0);
        send_term(5'b01000, 5'd1, 1'b1);
        step(1);
        // Abandon a held result: it must never be offered again.
        out_ready = 1'b0;
        send_term(5'b01111, 5'd3, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if ({out_valid, ovf, term_cnt} !== {2'b00, {CNT_W{1'b0}}})
            $display("FAIL reset_hold out_valid=%b ovf=%b term_cnt=%0d required 0/0/0", out_valid, ovf, term_cnt);
        else passed++;
        step(1);
    endtask

    task automatic test_toggle();
        push_exp(18, 2, 1'b0);
        signed_pp = 5'b01001;
        exp       = 5'd0;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(1);
        checks++;
        if ({out_valid, term_cnt, acc_out} !== {1'b0, CNT_W'(1), ACC_W'(9)})
            $display("FAIL toggle_idle out_valid=%b term_cnt=%0d acc_out=%0d required 0/1/9",
                     out_valid, term_cnt, acc_out);
        else passed++;
        in_valid = 1'b1;
        in_last  = 1'b1;
        step(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL toggle_done out_valid=%b required 1", out_valid);
        else passed++;
        step(1);
    endtask

    task automatic test_cnt_saturate();
        push_exp(2400, 255, 1'b0);
        for (int i = 0; i < 300; i++) send_term(5'b01000, 5'd0, (i == 299));
        step(1);
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 8; d++) begin
            int     len;
            longint sum;
            len = $urandom_range(1, 5);
            sum = 0;
            for (int t = 0; t < len; t++) begin
                logic [4:0] pp;
                logic [4:0] e;
                pp = 5'($urandom);
                e  = 5'($urandom);
                sum += term_val(pp, e);
                if (t == len - 1) push_exp(sum, len, 1'b0);
                send_term(pp, e, (t == len - 1));
            end
        end
        step(2);
    endtask

    task automatic test_overflow();
        logic [ACC_B-1:0] big_pos;
        logic [ACC_B-1:0] big_neg;
        logic [ACC_B-1:0] seven;
        big_pos = ACC_B'(64'd15 << 31);
        big_neg = ACC_B'(-(64'sd15 <<< 31));
`ifdef PP_ACC_SATURATE_EN
        seven = {1'b0, {(ACC_B-1){1'b1}}};
`else
        seven = ACC_B'(64'd9 << 31);
`endif
        send_b(5'b01111, 5'd31, 1'b1);
        checks++;
        if ({b_out_valid, b_acc, b_cnt, b_ovf} !== {1'b1, big_pos, CNT_W'(1), 1'b0})
            $display("FAIL ovf_single_pos out_valid=%b acc_out=%0d term_cnt=%0d ovf=%b required 1/%0d/1/0",
                     b_out_valid, b_acc, b_cnt, b_ovf, big_pos);
        else passed++;
        step(1);
        for (int i = 0; i < 7; i++) send_b(5'b01111, 5'd31, (i == 6));
        checks++;
        if ({b_out_valid, b_acc, b_cnt, b_ovf} !== {1'b1, seven, CNT_W'(7), 1'b1})
            $display("FAIL ovf_seven out_valid=%b acc_out=%0d term_cnt=%0d ovf=%b required 1/%0d/7/1",
                     b_out_valid, b_acc, b_cnt, b_ovf, seven);
        else passed++;
        step(1);
        send_b(5'b11111, 5'd31, 1'b1);
        checks++;
        if ({b_out_valid, b_acc, b_cnt, b_ovf} !== {1'b1, big_neg, CNT_W'(1), 1'b0})
            $display("FAIL ovf_cleared out_valid=%b acc_out=%0d term_cnt=%0d ovf=%b required 1/%0d/1/0",
                     b_out_valid, $signed(b_acc), b_cnt, b_ovf, $signed(big_neg));
        else passed++;
        step(1);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        signed_pp   = '0;
        exp         = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_pp        = '0;
        b_exp       = '0;
        b_last      = 1'b0;
        b_out_ready = 1'b1;

        test_reset();
        test_basic();
        test_zero_terms();
        test_hold();
        test_reset_mid();
        test_toggle();
        test_cnt_saturate();
        test_back_to_back();
        test_overflow();

        step(3);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drain pending=%0d required 0", sb.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
